// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared sizing and matching helpers for the serial pattern detector
package seq_detect_pkg;
  localparam int MAX_W = 64;
  function automatic int len_w(int w);
    return $clog2(w + 1);
  endfunction
  function automatic int clamp_len(int len, int w);
    return (len < 1) ? 1 : (len > w) ? w : len;
  endfunction
  // Compares only the low len bits; len == MAX_W wraps the shift to an all-ones mask
  function automatic logic pat_match(logic [MAX_W-1:0] hist, logic [MAX_W-1:0] pat, int len);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << len) - MAX_W'(1);
    return ((hist ^ pat) & mask) == '0;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector with registered match pulse
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                     PATTERN_W     = 8,
  parameter int                     CNT_W         = 16,
  parameter logic [PATTERN_W-1:0]   RESET_PATTERN = PATTERN_W'(8'b0000_1111),
  parameter int                     RESET_LEN     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           din_valid,
  input  logic                           din,
  input  logic                           cfg_load,
  input  logic [PATTERN_W-1:0]           cfg_pattern,
  input  logic [len_w(PATTERN_W)-1:0]    cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           dout,
  output logic [CNT_W-1:0]               match_count
);
  localparam int LEN_W = len_w(PATTERN_W);
  logic [PATTERN_W-1:0] hist_q, hist_d, hist_n, pat_q, pat_d;
  logic [LEN_W-1:0]     fill_q, fill_d, fill_inc, len_q, len_d;
  logic                 hit_q, hit_d, dout_q, ovl_q, ovl_d, accept, match;
  always_comb begin
    accept   = din_valid && !cfg_load;
    hist_n   = {hist_q[PATTERN_W-2:0], din};
    fill_inc = (fill_q == LEN_W'(PATTERN_W)) ? fill_q : fill_q + LEN_W'(1);
    match    = (fill_inc >= len_q) && pat_match(MAX_W'(hist_n), MAX_W'(pat_q), int'(len_q));
    hist_d   = accept ? hist_n : hist_q;
    // Non-overlapping mode restarts the fill count so the next match needs len fresh bits
    fill_d   = cfg_load ? '0 : !accept ? fill_q : (match && !ovl_q) ? '0 : fill_inc;
    hit_d    = accept && match;
    pat_d    = cfg_load ? cfg_pattern : pat_q;
    len_d    = cfg_load ? LEN_W'(clamp_len(int'(cfg_len), PATTERN_W)) : len_q;
    ovl_d    = cfg_load ? cfg_overlap : ovl_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
      dout_q <= 1'b0;
      pat_q  <= RESET_PATTERN;
      len_q  <= LEN_W'(RESET_LEN);
      ovl_q  <= 1'b1;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_d;
      dout_q <= hit_q;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc_i (hit_q),
    .clr_i (cnt_clr),
    .cnt_o (match_count)
  );
  assign dout = dout_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed vector table plus hand-written saturation sequence
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       reset, din_valid, din, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       dout;
  logic [3:0] match_count;
  int         ncmp = 0;
  int         nerr = 0;

  typedef struct {
    logic       r, v, d, ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, clr, ed;
    logic [3:0] ec;
  } vec_t;
  vec_t tbl[$];

  seq_detect_param #(.PATTERN_W(8), .CNT_W(4), .RESET_PATTERN(8'b0000_1111), .RESET_LEN(4)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout), .match_count(match_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, logic d, logic ld, logic [7:0] pat, logic [3:0] len,
                              logic ovl, logic clr, logic ed, logic [3:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.ld = ld; t.pat = pat; t.len = len;
    t.ovl = ovl; t.clr = clr; t.ed = ed; t.ec = ec;
    return t;
  endfunction
  function automatic void rst_v(logic ed, logic [3:0] ec);
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, ed, ec));
  endfunction
  function automatic void idle(logic ed, logic [3:0] ec);
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 0, ed, ec));
  endfunction
  function automatic void bit_v(logic d, logic ed, logic [3:0] ec);
    tbl.push_back(mk(0, 1, d, 0, 8'h00, 4'd0, 0, 0, ed, ec));
  endfunction
  // Loads drive a valid 1 on din to show the bit is ignored that cycle
  function automatic void load(logic [7:0] pat, logic [3:0] len, logic ovl, logic ed, logic [3:0] ec);
    tbl.push_back(mk(0, 1, 1, 1, pat, len, ovl, 0, ed, ec));
  endfunction

  task automatic apply(input vec_t t, input string nm);
    reset = t.r; din_valid = t.v; din = t.d; cfg_load = t.ld;
    cfg_pattern = t.pat; cfg_len = t.len; cfg_overlap = t.ovl; cnt_clr = t.clr;
    @(posedge clk);
    #1;
    ncmp++;
    if (dout !== t.ed || match_count !== t.ec) begin
      nerr++;
      $display("FAIL %s: got dout=%0b count=%0d, expected dout=%0b count=%0d",
               nm, dout, match_count, t.ed, t.ec);
    end
  endtask

  initial begin
    reset = 1; din_valid = 0; din = 0; cfg_load = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cnt_clr = 0;
    rst_v(0, 0);
    for (int i = 0; i < 4; i++) bit_v(1, 0, 0);
    idle(1, 1); idle(0, 1);
    load(8'h0F, 4, 1, 0, 1);
    for (int i = 0; i < 4; i++) bit_v(1, 0, 1);
    bit_v(1, 1, 2); bit_v(1, 1, 3); idle(1, 4); idle(0, 4);
    load(8'h0F, 4, 0, 0, 4);
    for (int i = 0; i < 4; i++) bit_v(1, 0, 4);
    bit_v(1, 1, 5); bit_v(1, 0, 5); idle(0, 5);
    load(8'h05, 3, 1, 0, 5);
    bit_v(1, 0, 5); bit_v(0, 0, 5); bit_v(1, 0, 5); bit_v(0, 1, 6); bit_v(1, 0, 6);
    load(8'h05, 3, 0, 1, 7);
    bit_v(1, 0, 7); bit_v(0, 0, 7); bit_v(1, 0, 7); bit_v(0, 1, 8); bit_v(1, 0, 8); idle(0, 8);
    load(8'h0F, 4, 1, 0, 8);
    bit_v(1, 0, 8); bit_v(1, 0, 8);
    for (int i = 0; i < 3; i++) idle(0, 8);
    bit_v(1, 0, 8); bit_v(1, 0, 8); idle(1, 9); idle(0, 9);
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 1, 0, 0));
    load(8'h0F, 4, 1, 0, 0);
    for (int i = 0; i < 3; i++) bit_v(1, 0, 0);
    rst_v(0, 0);
    bit_v(1, 0, 0); idle(0, 0); idle(0, 0);
    for (int i = 0; i < 3; i++) bit_v(1, 0, 0);
    rst_v(0, 0); idle(0, 0);
    load(8'h01, 0, 1, 0, 0);
    bit_v(1, 0, 0); bit_v(0, 1, 1); bit_v(1, 0, 1); bit_v(1, 1, 2); idle(1, 3); idle(0, 3);
    load(8'hAC, 15, 1, 0, 3);
    bit_v(1, 0, 3); bit_v(0, 0, 3); bit_v(1, 0, 3); bit_v(0, 0, 3);
    bit_v(1, 0, 3); bit_v(1, 0, 3); bit_v(0, 0, 3); bit_v(0, 0, 3);
    idle(1, 4); idle(0, 4);
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    apply(mk(0, 1, 1, 1, 8'h01, 4'd1, 1, 1, 0, 0), "sat_load_clr");
    for (int k = 1; k <= 17; k++)
      apply(mk(0, 1, 1, 0, 8'h00, 4'd0, 0, 0, k >= 2, 4'((k - 1 > 15) ? 15 : k - 1)),
            $sformatf("sat_bit%0d", k));
    apply(mk(0, 1, 1, 0, 8'h00, 4'd0, 0, 1, 1, 0), "clr_vs_inc");
    apply(mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 1, 1), "after_clr1");
    apply(mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 1), "after_clr2");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
